pipe_stage_buf: RTL and testbench

//  Parametrised pipeline stage register; generalises the fixed MEM/WB latch.

---
 rtl/pipe_stage_buf.sv | 105 ++++++++++
 tb/tb_pipe_stage_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register: DEPTH-entry in-order buffer with valid/ready,
// stall (en) and flush. Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 16
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNTW-1:0]            stall_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0 || CNTW == 0) begin : g_bad_param
    $error("pipe_stage_buf: DEPTH must be a power of two >= 1 and CNTW >= 1");
  end

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  occ_e             occ;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // A single-entry buffer keeps both pointers pinned at slot 0.
    return (DEPTH == 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)
      occ = OCC_EMPTY;
    else if (count == FULL_CNT)
      occ = OCC_FULL;
  end

  // Ready depends only on registered occupancy; reset blocks acceptance outright.
  always_comb begin
    in_ready  = en & nRST & (occ != OCC_FULL);
    out_valid = (occ != OCC_EMPTY);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    push      = en & in_valid & in_ready & ~flush;
    pop       = en & out_valid & out_ready & ~flush;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST)
      stall_cnt <= '0;
    else if (en && in_valid && !in_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNTW'(1);
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed table-driven bench for pipe_stage_buf (DEPTH=2, WIDTH=32); exercises the
// stall counter too when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [1:0]  sat_stall_cnt;
  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_data;
  logic [1:0]  sat_count;
`endif

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNTW(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNTW(2)) dut_sat (
    .CLK       (CLK),
    .nRST      (nRST),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (sat_in_ready),
    .out_valid (sat_out_valid),
    .out_data  (sat_out_data),
    .out_ready (out_ready),
    .count     (sat_count),
    .stall_cnt (sat_stall_cnt)
  );
`endif

  typedef struct {
    logic        en;
    logic        flush;
    logic        iv;
    logic [31:0] data;
    logic        ordy;
    logic        exp_ir;
    logic [1:0]  exp_cnt;
    logic        exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic f, input logic iv, input logic [31:0] d,
                              input logic o, input logic ir, input logic [1:0] c,
                              input logic ov, input logic [31:0] od);
    vec_t v;
    v.en = e; v.flush = f; v.iv = iv; v.data = d; v.ordy = o;
    v.exp_ir = ir; v.exp_cnt = c; v.exp_ov = ov; v.exp_od = od;
    return v;
  endfunction

  task automatic drive(input logic e, input logic f, input logic iv, input logic [31:0] d,
                       input logic o);
    en = e; flush = f; in_valid = iv; in_data = d; out_ready = o;
  endtask

  initial begin
    //                 en    flush iv    data          ordy  ir    cnt   ov    od
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd1, 1'b1, 32'hDEAD_BEEF);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_00A0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_00A0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_00B0, 1'b0, 1'b1, 2'd2, 1'b1, 32'h0000_00A0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_00C0, 1'b0, 1'b0, 2'd2, 1'b1, 32'h0000_00A0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_00C0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_00B0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_00C0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h0000_00C0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 2'd1, 1'b1, 32'h1234_5678);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 32'h9ABC_DEF0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h9ABC_DEF0);
    vecs[10] = mk(1'b1, 1'b0, 1'b1, 32'h0000_00D0, 1'b0, 1'b1, 2'd2, 1'b1, 32'h9ABC_DEF0);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 32'h0000_00E0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_00E0);
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h0000_00F0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_00E0);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h0000_00F0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_00E0);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 32'h0000_00F0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_00E0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    vecs[18] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0A0A, 1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_0A0A);
    vecs[19] = mk(1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);

    // Reset held two cycles with traffic present
    nRST = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b1);
    #1;
    chk("reset_in_ready_pre", 32'(in_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", out_data, 32'h0);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
    end
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].flush, vecs[i].iv, vecs[i].data, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      @(posedge CLK); #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_od);
    end

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter: reset clears, counts full-stall cycles, survives flush, saturates
    nRST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge CLK); #1;
    chk("perf_reset", 32'(stall_cnt), 32'd0);
    chk("perf_sat_reset", 32'(sat_stall_cnt), 32'd0);
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
    @(posedge CLK); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b0);
    @(posedge CLK); #1;
    chk("perf_fill_no_stall", 32'(stall_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0003, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    chk("perf_stall5", 32'(stall_cnt), 32'd5);
    chk("perf_sat3", 32'(sat_stall_cnt), 32'd3);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0003, 1'b0);
    @(posedge CLK); #1;
    chk("perf_en0_no_count", 32'(stall_cnt), 32'd5);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0003, 1'b0);
    @(posedge CLK); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge CLK); #1;
    chk("perf_flush_keeps", 32'(stall_cnt), 32'd6);
    chk("perf_flush_count", 32'(count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
